// File: rtl/video_pkg.sv
// video_pkg: shared constants and colour-dimming helper for the video output stage
package video_pkg;
  localparam int COLOR_W_DEF = 8;
  localparam int COLOR_W_MAX = 10;
  localparam logic SYNC_ACTIVE_LOW = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  // shift 1 halves the colour; larger shifts keep c - c/2^shift so the line stays brighter
  function automatic logic [COLOR_W_MAX-1:0] dim_color(input logic [COLOR_W_MAX-1:0] c, input int shift);
    return (shift <= 1) ? c >> 1 : c - (c >> shift);
  endfunction
endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay: enable-gated shift register with a reset fill value, depth 0 is a wire
module video_sync_delay #(
  parameter int W = 3,
  parameter int DEPTH = 2,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic         pixel_clock,
  input  logic         reset_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] stage [DEPTH];
    // shift one stage per enabled pixel; reset refills every stage with the idle value
    always_ff @(posedge pixel_clock or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= FILL;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/video_out_stage.sv
// video_out_stage: aligns sync/blank with colour, applies blanking and scanline dimming
module video_out_stage import video_pkg::*; #(
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int SYNC_DELAY = 2,
  parameter logic HSYNC_ACTIVE = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_ACTIVE = SYNC_ACTIVE_LOW,
  parameter int DIM_SHIFT = 1
) (
  input  logic               pixel_clock,
  input  logic               reset_n,
  input  logic               pixel_ce,
  input  logic [COLOR_W-1:0] vga_red_data,
  input  logic [COLOR_W-1:0] vga_green_data,
  input  logic [COLOR_W-1:0] vga_blue_data,
  input  logic               h_synch,
  input  logic               v_synch,
  input  logic               blank,
  input  logic               scanline_en,
  output logic               VGA_OUT_HSYNC,
  output logic               VGA_OUT_VSYNC,
  output logic [COLOR_W-1:0] VGA_OUT_RED,
  output logic [COLOR_W-1:0] VGA_OUT_GREEN,
  output logic [COLOR_W-1:0] VGA_OUT_BLUE,
  output logic               line_odd
);
  localparam logic H_IDLE = ~HSYNC_ACTIVE;
  localparam logic V_IDLE = ~VSYNC_ACTIVE;
  logic tail_h, tail_v, tail_blank;
  logic hs_start, vs_start, parity_next, dim;
  logic [COLOR_W-1:0] red_dim, green_dim, blue_dim;
  video_sync_delay #(
    .W(3),
    .DEPTH(SYNC_DELAY),
    .FILL({H_IDLE, V_IDLE, 1'b1})
  ) u_sync_delay (
    .pixel_clock(pixel_clock),
    .reset_n(reset_n),
    .ce(pixel_ce),
    .d({h_synch, v_synch, blank}),
    .q({tail_h, tail_v, tail_blank})
  );
  // the output sync registers already hold the previous tail value, so edges are detected against them
  assign hs_start = (tail_h == HSYNC_ACTIVE) && (VGA_OUT_HSYNC != HSYNC_ACTIVE);
  assign vs_start = (tail_v == VSYNC_ACTIVE) && (VGA_OUT_VSYNC != VSYNC_ACTIVE);
  assign parity_next = vs_start ? 1'b0 : hs_start ? ~line_odd : line_odd;
  assign dim = scanline_en && parity_next;
  assign red_dim = COLOR_W'(dim_color(COLOR_W_MAX'(vga_red_data), DIM_SHIFT));
  assign green_dim = COLOR_W'(dim_color(COLOR_W_MAX'(vga_green_data), DIM_SHIFT));
  assign blue_dim = COLOR_W'(dim_color(COLOR_W_MAX'(vga_blue_data), DIM_SHIFT));
  // output register: syncs from the tail, colours blanked or dimmed, parity carried with the pixel
  always_ff @(posedge pixel_clock or negedge reset_n)
    if (!reset_n) begin
      VGA_OUT_HSYNC <= H_IDLE;
      VGA_OUT_VSYNC <= V_IDLE;
      VGA_OUT_RED <= '0;
      VGA_OUT_GREEN <= '0;
      VGA_OUT_BLUE <= '0;
      line_odd <= 1'b0;
    end else if (pixel_ce) begin
      VGA_OUT_HSYNC <= tail_h;
      VGA_OUT_VSYNC <= tail_v;
      VGA_OUT_RED <= tail_blank ? '0 : dim ? red_dim : vga_red_data;
      VGA_OUT_GREEN <= tail_blank ? '0 : dim ? green_dim : vga_green_data;
      VGA_OUT_BLUE <= tail_blank ? '0 : dim ? blue_dim : vga_blue_data;
      line_odd <= parity_next;
    end
endmodule
